// File: rtl/spart_pkg.sv
// spart_pkg: shared FSM state and parity-mode encodings for the SPART transmitter
package spart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   function automatic logic par_en(input logic [1:0] mode);
      return mode == PAR_EVEN || mode == PAR_ODD;
   endfunction

endpackage

// File: rtl/spart_fifo.sv
// spart_fifo: transmit buffer; full/empty come from the pre-edge occupancy
module spart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;
   assign full    = cnt_q == CW'(DEPTH);
   assign empty   = cnt_q == '0;
   assign dout    = mem_q[rd_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // pointers wrap naturally because DEPTH is a power of two
   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_q] = din;
      wr_d  = wr_q + AW'(do_push);
      rd_d  = rd_q + AW'(do_pop);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end
   // storage is not cleared on reset; only the pointers define validity
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/spart_tx_cfg.sv
// spart_tx_cfg: buffered serial transmitter with per-frame parity and stop-bit configuration
module spart_tx_cfg #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              baud_clk,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [1:0]        parity_mode,
   input  logic              two_stop,
   output logic              txd,
   output logic              tbr,
   output logic              busy,
   output logic              overflow
);
   import spart_pkg::*;
   localparam int BW = $clog2(DATA_W);
   state_e            state_q, state_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              pen_q, pen_d, pbit_q, pbit_d, two_q, two_d, stop_q, stop_d, txd_q, txd_d;
   logic [DATA_W-1:0] head;
   logic              full, empty, push, pop, last_stop;
   spart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (tx_data),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );
   assign txd = txd_q;
   // state register: everything clears to an idle, high line
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bit_q   <= '0;
         sh_q    <= '0;
         pen_q   <= 1'b0;
         pbit_q  <= 1'b0;
         two_q   <= 1'b0;
         stop_q  <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         pen_q   <= pen_d;
         pbit_q  <= pbit_d;
         two_q   <= two_d;
         stop_q  <= stop_d;
         txd_q   <= txd_d;
      end
   end
   // next state: advance only on baud ticks; a pop loads a fresh frame and latches its config
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      pen_d   = pen_q;
      pbit_d  = pbit_q;
      two_d   = two_q;
      stop_d  = stop_q;
      txd_d   = txd_q;
      if (baud_clk) begin
         case (state_q)
            START: begin
               txd_d   = sh_q[0];
               sh_d    = sh_q >> 1;
               bit_d   = '0;
               state_d = DATA;
            end
            DATA: begin
               if (bit_q == BW'(DATA_W - 1)) begin
                  txd_d   = pen_q ? pbit_q : 1'b1;
                  state_d = pen_q ? PARITY : STOP;
                  stop_d  = 1'b0;
               end else begin
                  txd_d = sh_q[0];
                  sh_d  = sh_q >> 1;
                  bit_d = bit_q + BW'(1);
               end
            end
            PARITY: begin
               txd_d   = 1'b1;
               state_d = STOP;
               stop_d  = 1'b0;
            end
            STOP: begin
               stop_d  = 1'b1;
               state_d = last_stop ? IDLE : STOP;
            end
            IDLE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      if (pop) begin
         state_d = START;
         txd_d   = 1'b0;
         sh_d    = head;
         bit_d   = '0;
         stop_d  = 1'b0;
         pen_d   = par_en(parity_mode);
         pbit_d  = ^head ^ (parity_mode == PAR_ODD);
         two_d   = two_stop;
      end
   end
   // outputs: pop at idle or at the end of the final stop tick; writes and ticks are ignored in reset
   always_comb begin
      last_stop = !two_q || stop_q;
      pop       = baud_clk && !rst && !empty && (state_q == IDLE || (state_q == STOP && last_stop));
      push      = wr_en && !rst;
      overflow  = wr_en && !rst && full;
      tbr       = !full;
      busy      = state_q != IDLE;
   end
endmodule
